// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the debug-port UART.
//   CLK_HZ / BAUD / CLKS_PER_BIT : bit timing for the 27 MHz system clock
//   LINE_IDLE / START_BIT / STOP_BIT : serial line levels
//   rxState_t : receiver FSM states
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int CLK_HZ       = 27_000_000;
   localparam int BAUD         = 115200;
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rxState_t;

endpackage

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for an asynchronous pin. Both flops reset to
// RESET_VAL so that an idle-high serial line looks idle straight out of reset.
//   clk      : destination clock
//   reset_n  : asynchronous active-low reset
//   i_async  : asynchronous input pin
//   o_sync   : synchronised copy of i_async, two clocks late
// ---------------------------------------------------------------------------
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // The first flop may go metastable; the second gives it a full cycle to
   // settle before anything downstream looks at the value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/uart_debug_rx.sv
// ---------------------------------------------------------------------------
// uart_debug_rx
// 8N1 UART receiver for the debug port. Samples the middle of each bit,
// LSB first, and presents each byte in a one-entry valid/ready holding
// register. Bad stop bits and bytes that arrive while the holding register
// is still full are reported as single-cycle pulses.
//   clk         : system clock (27 MHz)
//   reset_n     : asynchronous active-low reset
//   uart_rx     : serial input, idles high
//   rx_data     : received byte, valid while rx_valid is high
//   rx_valid    : byte available
//   rx_ready    : consumer takes the byte when rx_valid && rx_ready
//   framing_err : pulse, stop bit sampled low
//   overrun     : pulse, completed byte dropped because the register was full
//   busy        : receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_debug_rx #(
   parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       framing_err,
   output logic       overrun,
   output logic       busy
);

   import uart_pkg::*;

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CNT_W    = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

   logic             w_rxS;
   rxState_t         r_state;
   rxState_t         w_nextState;
   logic [CNT_W-1:0] r_baudCnt;
   logic [2:0]       r_bitIdx;
   logic [7:0]       r_shift;
   logic [7:0]       r_data;
   logic             r_valid;
   logic             r_framingErr;
   logic             r_overrun;

   logic w_sampleStart;
   logic w_sampleData;
   logic w_sampleStop;
   logic w_clearCnt;
   logic w_deliver;
   logic w_frameBad;

   // Bring the pin into the clock domain; nothing below looks at uart_rx.
   uart_sync2 #(
      .RESET_VAL (LINE_IDLE)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_async (uart_rx),
      .o_sync  (w_rxS)
   );

   // State register for the receive FSM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= RX_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. The sample strobes mark the cycle in which the line is
   // read: half a bit after the falling edge for the start bit, then one full
   // bit later for every data bit and the stop bit. A start bit that is no
   // longer low at its mid-point is treated as a glitch and silently dropped.
   // After a bad stop bit the FSM parks until the line goes high again so a
   // held-low line or break is not decoded as a string of 0x00 bytes.
   always_comb begin
      w_nextState   = r_state;
      w_sampleStart = 1'b0;
      w_sampleData  = 1'b0;
      w_sampleStop  = 1'b0;
      case (r_state)
         RX_IDLE: begin
            if (w_rxS == START_BIT) begin
               w_nextState = RX_START;
            end
         end
         RX_START: begin
            if (r_baudCnt == HALF_LAST) begin
               w_sampleStart = 1'b1;
               w_nextState   = (w_rxS == START_BIT) ? RX_DATA : RX_IDLE;
            end
         end
         RX_DATA: begin
            if (r_baudCnt == BIT_LAST) begin
               w_sampleData = 1'b1;
               if (r_bitIdx == 3'd7) begin
                  w_nextState = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (r_baudCnt == BIT_LAST) begin
               w_sampleStop = 1'b1;
               w_nextState  = (w_rxS == STOP_BIT) ? RX_IDLE : RX_WAIT_HIGH;
            end
         end
         RX_WAIT_HIGH: begin
            if (w_rxS == LINE_IDLE) begin
               w_nextState = RX_IDLE;
            end
         end
         default: begin
            w_nextState = RX_IDLE;
         end
      endcase
   end

   assign w_clearCnt = (w_nextState != r_state) || w_sampleStart || w_sampleData || w_sampleStop;
   assign w_deliver  = w_sampleStop && (w_rxS == STOP_BIT);
   assign w_frameBad = w_sampleStop && (w_rxS != STOP_BIT);

   // Baud counter restarts on every state change and every sample so each
   // sample point is measured from the previous one. It rests at zero in the
   // states that do not time anything.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_baudCnt <= '0;
      end else if (w_clearCnt || (r_state == RX_IDLE) || (r_state == RX_WAIT_HIGH)) begin
         r_baudCnt <= '0;
      end else begin
         r_baudCnt <= r_baudCnt + 1'b1;
      end
   end

   // Data bits arrive LSB first; the bit index is reset when a valid start
   // bit is confirmed and steps after each data sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bitIdx <= '0;
         r_shift  <= '0;
      end else if (w_sampleStart) begin
         r_bitIdx <= '0;
      end else if (w_sampleData) begin
         r_shift[r_bitIdx] <= w_rxS;
         r_bitIdx          <= r_bitIdx + 1'b1;
      end
   end

   // Holding register and status pulses. A byte completing while the
   // register is empty, or in the same cycle the consumer takes the old
   // byte, is loaded. Otherwise the new byte is dropped and overrun pulses.
   // A consume with no delivery just clears valid; rx_data keeps its value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_framingErr <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_framingErr <= w_frameBad;
         r_overrun    <= 1'b0;
         if (w_deliver) begin
            if (!r_valid || rx_ready) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_data     = r_data;
   assign rx_valid    = r_valid;
   assign framing_err = r_framingErr;
   assign overrun     = r_overrun;
   assign busy        = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_debug_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_debug_rx
// Directed bench for uart_debug_rx at the real 234 clocks-per-bit timing.
// ---------------------------------------------------------------------------
module tb_uart_debug_rx;

   localparam int BIT_CLKS = 234;

   logic       clk;
   logic       reset_n;
   logic       uart_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       framing_err;
   logic       overrun;
   logic       busy;

   int compareCount = 0;
   int failCount    = 0;

   int   validRise;
   int   validFall;
   int   validHigh;
   int   framingPulses;
   int   overrunPulses;
   int   bothPulses = 0;
   logic [7:0] lastData;
   logic prevValid;

   uart_debug_rx dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .uart_rx     (uart_rx),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .framing_err (framing_err),
      .overrun     (overrun),
      .busy        (busy)
   );

   // 10 ns system clock; inputs change and outputs are sampled on negedges.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event counters for pulses that happen in the middle of a frame.
   always @(negedge clk) begin
      if (rx_valid && !prevValid) begin
         validRise = validRise + 1;
         lastData  = rx_data;
      end
      if (!rx_valid && prevValid) begin
         validFall = validFall + 1;
      end
      if (rx_valid)    validHigh     = validHigh + 1;
      if (framing_err) framingPulses = framingPulses + 1;
      if (overrun)     overrunPulses = overrunPulses + 1;
      if (framing_err && overrun) bothPulses = bothPulses + 1;
      prevValid = rx_valid;
   end

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clearCounts();
      validRise     = 0;
      validFall     = 0;
      validHigh     = 0;
      framingPulses = 0;
      overrunPulses = 0;
      lastData      = 8'h00;
      prevValid     = rx_valid;
   endtask

   // One 8N1 frame; stopLowBits > 0 holds the stop bit low that many bit
   // times before returning the line high for one bit time.
   task automatic applyStimulus(input logic [7:0] data, input int stopLowBits);
      uart_rx = 1'b0;
      waitClocks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         uart_rx = data[i];
         waitClocks(BIT_CLKS);
      end
      if (stopLowBits > 0) begin
         uart_rx = 1'b0;
         waitClocks(BIT_CLKS * stopLowBits);
      end
      uart_rx = 1'b1;
      waitClocks(BIT_CLKS);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount = compareCount + 1;
      assert (observed === expected) else begin
         failCount = failCount + 1;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      uart_rx  = 1'b1;
      rx_ready = 1'b0;
      clearCounts();
      waitClocks(5);

      $display("[TB] reset values");
      checkOutput("rst_rx_data",     32'(rx_data),     32'h00);
      checkOutput("rst_rx_valid",    32'(rx_valid),    32'h0);
      checkOutput("rst_busy",        32'(busy),        32'h0);
      checkOutput("rst_framing_err", 32'(framing_err), 32'h0);
      checkOutput("rst_overrun",     32'(overrun),     32'h0);
      reset_n = 1'b1;
      waitClocks(20);

      $display("[TB] clean frame 0x48 with rx_ready high");
      clearCounts();
      rx_ready = 1'b1;
      applyStimulus(8'h48, 0);
      checkOutput("t1_valid_rises",  32'(validRise),     32'd1);
      checkOutput("t1_valid_cycles", 32'(validHigh),     32'd1);
      checkOutput("t1_data",         32'(lastData),      32'h48);
      checkOutput("t1_framing",      32'(framingPulses), 32'd0);
      checkOutput("t1_busy_after",   32'(busy),          32'h0);
      checkOutput("t1_valid_after",  32'(rx_valid),      32'h0);
      waitClocks(20);

      $display("[TB] 50-clock glitch on the line");
      clearCounts();
      uart_rx = 1'b0;
      waitClocks(50);
      uart_rx = 1'b1;
      checkOutput("t2_busy_at_50",   32'(busy), 32'h1);
      waitClocks(50);
      checkOutput("t2_busy_at_100",  32'(busy), 32'h1);
      waitClocks(25);
      checkOutput("t2_busy_at_125",  32'(busy), 32'h0);
      checkOutput("t2_no_valid",     32'(validRise),     32'd0);
      checkOutput("t2_no_framing",   32'(framingPulses), 32'd0);
      waitClocks(50);

      $display("[TB] 0xA5 with stop bit low for two bit times, then 0x3C");
      clearCounts();
      fork
         applyStimulus(8'hA5, 2);
         begin
            waitClocks(2490);
            checkOutput("t3_busy_wait_high", 32'(busy), 32'h1);
         end
      join
      checkOutput("t3_framing_once", 32'(framingPulses), 32'd1);
      checkOutput("t3_no_valid",     32'(validRise),     32'd0);
      checkOutput("t3_busy_after",   32'(busy),          32'h0);
      waitClocks(20);
      clearCounts();
      applyStimulus(8'h3C, 0);
      checkOutput("t3_next_valid",   32'(validRise),     32'd1);
      checkOutput("t3_next_data",    32'(lastData),      32'h3C);
      checkOutput("t3_next_framing", 32'(framingPulses), 32'd0);
      waitClocks(20);

      $display("[TB] back-to-back 0x55, 0xAA with rx_ready low");
      clearCounts();
      rx_ready = 1'b0;
      applyStimulus(8'h55, 0);
      applyStimulus(8'hAA, 0);
      checkOutput("t4_valid_held",   32'(rx_valid),      32'h1);
      checkOutput("t4_data_kept",    32'(rx_data),       32'h55);
      checkOutput("t4_overrun_once", 32'(overrunPulses), 32'd1);
      checkOutput("t4_no_framing",   32'(framingPulses), 32'd0);
      rx_ready = 1'b1;
      waitClocks(1);
      rx_ready = 1'b0;
      waitClocks(1);
      checkOutput("t4_consumed",     32'(rx_valid),      32'h0);
      checkOutput("t4_data_holds",   32'(rx_data),       32'h55);
      waitClocks(20);

      $display("[TB] consume on the exact delivery cycle");
      clearCounts();
      applyStimulus(8'h0A, 0);
      checkOutput("t5_pending_valid", 32'(rx_valid), 32'h1);
      checkOutput("t5_pending_data",  32'(rx_data),  32'h0A);
      waitClocks(20);
      clearCounts();
      fork
         applyStimulus(8'h0D, 0);
         begin
            waitClocks(2225);
            rx_ready = 1'b1;
            waitClocks(1);
            rx_ready = 1'b0;
         end
      join
      checkOutput("t5_new_data",      32'(rx_data),       32'h0D);
      checkOutput("t5_valid_stays",   32'(rx_valid),      32'h1);
      checkOutput("t5_no_valid_drop", 32'(validFall),     32'd0);
      checkOutput("t5_no_overrun",    32'(overrunPulses), 32'd0);
      rx_ready = 1'b1;
      waitClocks(1);
      rx_ready = 1'b0;
      waitClocks(20);

      $display("[TB] reset during bit 4 of 0xFF, then 0x21");
      clearCounts();
      rx_ready = 1'b1;
      fork
         applyStimulus(8'hFF, 0);
         begin
            waitClocks(1270);
            reset_n = 1'b0;
            waitClocks(1);
            checkOutput("t6_busy_in_reset",  32'(busy),     32'h0);
            checkOutput("t6_valid_in_reset", 32'(rx_valid), 32'h0);
            checkOutput("t6_data_in_reset",  32'(rx_data),  32'h00);
            waitClocks(2);
            reset_n = 1'b1;
         end
      join
      checkOutput("t6_cut_no_valid",   32'(validRise),     32'd0);
      checkOutput("t6_cut_no_framing", 32'(framingPulses), 32'd0);
      checkOutput("t6_busy_idle",      32'(busy),          32'h0);
      waitClocks(20);
      clearCounts();
      applyStimulus(8'h21, 0);
      checkOutput("t6_next_valid", 32'(validRise), 32'd1);
      checkOutput("t6_next_data",  32'(lastData),  32'h21);
      waitClocks(10);

      checkOutput("never_both_pulses", 32'(bothPulses), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule

// File: doc/uart_debug_rx.md
Name: uart_debug_rx

Overview:
8N1 UART receiver for the debug port: 27 MHz system clock, 115200 baud. Deserialises the uart_rx pin into bytes and presents each byte on a one-entry valid/ready output register. Sits at the pin boundary, opposite the debug transmitter, and feeds the debug command/loopback logic. Flags framing errors and overruns.

Parameters:
CLKS_PER_BIT, 234, system clocks per bit (27,000,000 / 115200).
HALF_BIT, CLKS_PER_BIT/2 = 117, delay from start-bit detection to the start-bit mid-point check.

Ports:
clk  in  1  system clock, 27 MHz
reset_n  in  1  asynchronous, active-low reset
uart_rx  in  1  asynchronous serial input; idles high
rx_data  out  8  received byte; valid while rx_valid=1
rx_valid  out  1  byte available
rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready
framing_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: completed byte dropped because the holding register was full
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (reset_n).
- Reset values: rx_data=0x00, rx_valid=0, framing_err=0, overrun=0, busy=0.
  - Synchroniser flops reset to 1.
  - FSM=IDLE, bit counter=0, baud counter=0.
- Input path: uart_rx passes through a 2-flop synchroniser giving rx_s. All decisions use rx_s only.
- Baud counter: width $clog2(CLKS_PER_BIT). It is cleared on every state entry and on every sample.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 -> START.
  - START: after HALF_BIT cycles, sample rx_s.
    - 0 -> DATA, bit_idx=0.
    - 1 -> IDLE. This is a glitch: no error, no output.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[bit_idx], LSB first. After bit_idx==7 is sampled -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1 -> deliver the byte, then IDLE.
    - 0 -> pulse framing_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then IDLE. This prevents a break or held-low line from being decoded as 0x00 frames.
- Delivery, evaluated in the cycle the stop bit is sampled; outputs update on the next edge (latency: rx_valid rises 1 cycle after the stop-bit sample point):
  - rx_valid==0: load rx_data, set rx_valid.
  - rx_valid==1 && rx_ready==1 (simultaneous consume): load the new byte; rx_valid stays 1; no overrun.
  - rx_valid==1 && rx_ready==0: keep the old byte, drop the new one, pulse overrun.
- Consume: rx_valid && rx_ready with no simultaneous delivery -> rx_valid=0 next cycle. rx_data holds its last value.
- rx_ready is ignored while rx_valid==0.
- framing_err and overrun are single-cycle pulses; they are never asserted together.
- Reset mid-frame: everything returns to reset values immediately. The partial byte is lost. After release, a frame tail still low on the line is re-entered via START. A stop bit that fails the check goes through framing_err/WAIT_HIGH; no spurious rx_valid.
- No parity, no baud auto-detect, single-sample per bit (no majority vote).

Decomposition:
- Shared package uart_pkg holds:
  - CLK_HZ (27_000_000), BAUD (115200), derived CLKS_PER_BIT;
  - UART line-level constants IDLE=1, START_BIT=0, STOP_BIT=1;
  - rx state enum (IDLE, START, DATA, STOP, WAIT_HIGH).
- One sub-module: uart_sync2, the 2-flop synchroniser with reset value 1 (reusable for other async pins). The FSM and holding register stay in uart_debug_rx.

Test Plan:
- Drive 0x48 at 234 clk/bit, rx_ready=1 -> rx_valid pulses for 1 cycle with rx_data=0x48; framing_err=0; busy low again after the stop-bit sample.
- Drive 0 for 50 clks then 1 -> no rx_valid, no framing_err; busy high about 117 clks then low.
- Drive 0xA5 with the stop bit forced 0 for 2 bit times -> framing_err one pulse, rx_valid stays 0; the next clean frame 0x3C is received correctly after the line returns high.
- Drive back-to-back 0x55, 0xAA with rx_ready=0 -> rx_data=0x55, rx_valid=1, overrun one pulse at the end of 0xAA. Then raise rx_ready for 1 cycle -> rx_valid=0.
- Hold rx_ready high on the exact delivery cycle of 0x0D while 0x0A is pending -> rx_data becomes 0x0D, rx_valid stays 1, no overrun.
- Assert reset_n=0 during bit 4 of 0xFF, release, send 0x21 -> no rx_valid for the cut frame; 0x21 is received correctly.
